alu_entry_sequencer: RTL and testbench

// - Front end of the board calculator. It debounces the ENTER and CLEAR push-buttons.
// - Operands A and B are captured in turn from the slide switches.
// - The opcode-selected operation runs on A and B, and the result is registered.
// - Output is a 6-bit two's-complement value feeding the two-digit seven-segment display stage directly.

---
 rtl/alu_entry_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_entry_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_entry_sequencer.sv
// -----------------------------------------------------------------------------
// alu_entry_sequencer
//
// Front end of the board calculator. Debounces the ENTER and CLEAR buttons,
// captures operands A and B from the slide switches in turn, runs the
// opcode-selected operation and holds the signed result for the display.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high, clears all state
//   sw           in   OPW    operand switches, signed, quasi-static
//   op           in   2      opcode switches (00 ADD, 01 SUB, 10 AND, 11 MAX)
//   enter_btn    in   1      raw ENTER button, active-high, bouncy
//   clear_btn    in   1      raw CLEAR button, active-high, bouncy
//   sum          out  OPW+1  value to display, signed
//   result_valid out  1      sum holds a computed result
//   range_err    out  1      held result is -2^OPW (magnitude not displayable)
//   state_led    out  2      FSM state encoding
// -----------------------------------------------------------------------------
module alu_entry_sequencer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int OPW             = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] sw,
   input  logic [1:0]     op,
   input  logic           enter_btn,
   input  logic           clear_btn,
   output logic [OPW:0]   sum,
   output logic           result_valid,
   output logic           range_err,
   output logic [1:0]     state_led
);

   localparam logic [1:0] S_A  = 2'b00;
   localparam logic [1:0] S_B  = 2'b01;
   localparam logic [1:0] S_EX = 2'b10;
   localparam logic [1:0] S_SH = 2'b11;

   // +1 keeps the counter at least one bit wide for tiny debounce values
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Most negative result: the only value whose magnitude cannot be shown
   localparam logic signed [OPW:0] RES_MIN = {1'b1, {OPW{1'b0}}};

   // ---------------------------------------------------------------------
   // Button conditioning: bit 0 = ENTER, bit 1 = CLEAR
   // ---------------------------------------------------------------------
   logic [1:0] w_btn_raw;
   logic [1:0] w_btn_p;
   logic       w_enter_p;
   logic       w_clear_p;

   assign w_btn_raw = {clear_btn, enter_btn};
   assign w_enter_p = w_btn_p[0];
   assign w_clear_p = w_btn_p[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          r_sync1;
         logic          r_sync2;
         logic          r_accepted;
         logic          r_pulse;
         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync1    <= 1'b0;
               r_sync2    <= 1'b0;
               r_accepted <= 1'b0;
               r_pulse    <= 1'b0;
               r_cnt      <= '0;
            end else begin
               r_sync1 <= w_btn_raw[gi];
               r_sync2 <= r_sync1;
               r_pulse <= 1'b0;
               if (r_sync2 != r_accepted) begin
                  // Pending change: accept it only after it has stayed
                  // stable for the full debounce window.
                  if (r_cnt == CNT_MAX) begin
                     r_accepted <= r_sync2;
                     r_cnt      <= '0;
                     // Pulse only on an accepted press, never on release
                     r_pulse    <= r_sync2;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
         end

         assign w_btn_p[gi] = r_pulse;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Arithmetic on sign-extended operands
   // ---------------------------------------------------------------------
   logic [OPW-1:0]    r_a;
   logic [OPW-1:0]    r_b;
   logic signed [OPW:0] r_res;
   logic [1:0]        r_state;
   logic              r_result_valid;
   logic              r_range_err;

   logic signed [OPW:0] w_a_ext;
   logic signed [OPW:0] w_b_ext;
   logic signed [OPW:0] w_sw_ext;
   logic signed [OPW:0] w_res;

   assign w_a_ext  = {r_a[OPW-1], r_a};
   assign w_b_ext  = {r_b[OPW-1], r_b};
   assign w_sw_ext = {sw[OPW-1], sw};

   // One extra bit means ADD/SUB of two OPW-bit values can never overflow
   always_comb begin
      w_res = '0;
      case (op)
         2'b00:   w_res = w_a_ext + w_b_ext;
         2'b01:   w_res = w_a_ext - w_b_ext;
         2'b10:   w_res = w_a_ext & w_b_ext;
         default: w_res = (w_a_ext > w_b_ext) ? w_a_ext : w_b_ext;
      endcase
   end

   // ---------------------------------------------------------------------
   // Entry FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_A;
         r_a            <= '0;
         r_b            <= '0;
         r_res          <= '0;
         r_result_valid <= 1'b0;
         r_range_err    <= 1'b0;
      end else if (w_clear_p) begin
         // CLEAR has priority over a coincident ENTER in every state
         r_state        <= S_A;
         r_a            <= '0;
         r_b            <= '0;
         r_res          <= '0;
         r_result_valid <= 1'b0;
         r_range_err    <= 1'b0;
      end else begin
         case (r_state)
            S_A: begin
               if (w_enter_p) begin
                  r_a     <= sw;
                  r_state <= S_B;
               end
            end
            S_B: begin
               if (w_enter_p) begin
                  r_b     <= sw;
                  r_state <= S_EX;
               end
            end
            S_EX: begin
               // op is sampled here, so it may change after operand entry
               r_res          <= w_res;
               r_result_valid <= 1'b1;
               r_range_err    <= (w_res == RES_MIN);
               r_state        <= S_SH;
            end
            default: begin
               // Chained entry: a new A starts the next calculation
               if (w_enter_p) begin
                  r_a            <= sw;
                  r_result_valid <= 1'b0;
                  r_range_err    <= 1'b0;
                  r_state        <= S_B;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: held result in S_SH, live switch preview otherwise. Reset is
   // folded in so the preview path also reads zero while reset is high.
   // ---------------------------------------------------------------------
   assign sum          = reset ? '0 : ((r_state == S_SH) ? r_res : w_sw_ext);
   assign result_valid = r_result_valid;
   assign range_err    = r_range_err;
   assign state_led    = r_state;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
module tb_alu_entry_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] sw;
   logic [1:0] op;
   logic       enter_btn;
   logic       clear_btn;
   logic [5:0] sum;
   logic       result_valid;
   logic       range_err;
   logic [1:0] state_led;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [5:0] sum;
      logic       re;
   } exp_t;

   exp_t sb[$];

   alu_entry_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .OPW(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw(sw),
      .op(op),
      .enter_btn(enter_btn),
      .clear_btn(clear_btn),
      .sum(sum),
      .result_valid(result_valid),
      .range_err(range_err),
      .state_led(state_led)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Hold the button(s) long enough to debounce, then release long enough
   // for the release to be accepted as well.
   task automatic press(input logic en, input logic cl);
      enter_btn = en;
      clear_btn = cl;
      repeat (8) tick();
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      repeat (8) tick();
   endtask

   task automatic wait_state(input logic [1:0] target, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (state_led == target) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Reference result, computed with plain integer arithmetic
   function automatic exp_t model(input int a, input int b, input logic [1:0] o);
      int         r;
      logic [5:0] ea;
      logic [5:0] eb;
      logic [5:0] andv;
      exp_t       e;
      ea   = 6'(a);
      eb   = 6'(b);
      andv = ea & eb;
      case (o)
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         2'd2:    r = int'($signed(andv));
         default: r = (a > b) ? a : b;
      endcase
      e.sum = 6'(r);
      e.re  = (r == -32);
      return e;
   endfunction

   task automatic do_calc(input int a, input int b, input logic [1:0] o);
      sw = 5'(a);
      press(1'b1, 1'b0);
      sw = 5'(b);
      op = o;
      press(1'b1, 1'b0);
      sb.push_back(model(a, b, o));
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      sw        = 5'd5;
      op        = 2'b00;
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      repeat (3) tick();
      checks++;
      if (sum !== 6'd0) begin
         errors++;
         $display("FAIL reset_sum: got %b expected %b", sum, 6'd0);
      end
      checks++;
      if (result_valid !== 1'b0 || range_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%b rerr=%b expected 0 0", result_valid, range_err);
      end
      checks++;
      if (state_led !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: got %b expected 00", state_led);
      end
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if (sum !== 6'b000101 || state_led !== 2'b00) begin
         errors++;
         $display("FAIL reset_preview: got sum=%b state=%b expected 000101 00", sum, state_led);
      end
      $display("test_reset done");
   endtask

   task automatic run_table(input string name, input int ta[], input int tb[], input logic [1:0] to[]);
      bit   ok;
      exp_t e;
      for (int i = 0; i < ta.size(); i++) begin
         do_calc(ta[i], tb[i], to[i]);
         wait_state(2'b11, ok);
         e = sb.pop_front();
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s_timeout[%0d]: got state=%b expected 11", name, i, state_led);
         end
         checks++;
         if (sum !== e.sum || range_err !== e.re || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d] A=%0d B=%0d op=%0d: got sum=%b rerr=%b valid=%b expected sum=%b rerr=%b valid=1",
                     name, i, ta[i], tb[i], to[i], sum, range_err, result_valid, e.sum, e.re);
         end
         $display("%s[%0d] A=%0d B=%0d op=%0d sum=%b rerr=%b", name, i, ta[i], tb[i], to[i], sum, range_err);
      end
   endtask

   task automatic test_arith;
      int         ta[] = '{5, 6, -6, -6, -9, 15, -16, 7};
      int         tb[] = '{-3, -4, 7, 3, -2, 15, 15, -8};
      logic [1:0] to[] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
      run_table("arith", ta, tb, to);
   endtask

   task automatic test_range;
      int         ta[] = '{-16, -16, -16};
      int         tb[] = '{15, -16, -16};
      logic [1:0] to[] = '{2'b01, 2'b01, 2'b00};
      run_table("range", ta, tb, to);
   endtask

   task automatic test_reset_mid;
      checks++;
      if (state_led !== 2'b11 || result_valid !== 1'b1) begin
         errors++;
         $display("FAIL resetmid_pre: got state=%b valid=%b expected 11 1", state_led, result_valid);
      end
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (sum !== 6'd0 || result_valid !== 1'b0 || range_err !== 1'b0 || state_led !== 2'b00) begin
         errors++;
         $display("FAIL resetmid_async: got sum=%b valid=%b rerr=%b state=%b expected 000000 0 0 00",
                  sum, result_valid, range_err, state_led);
      end
      tick();
      reset = 1'b0;
      repeat (4) tick();
      checks++;
      if (state_led !== 2'b00 || sum !== 6'b110000) begin
         errors++;
         $display("FAIL resetmid_release: got state=%b sum=%b expected 00 110000", state_led, sum);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_bounce;
      bit moved = 1'b0;
      int n;
      sw = 5'd3;
      for (int k = 0; k < 10; k++) begin
         enter_btn = (k % 2 == 0);
         tick();
         if (state_led !== 2'b00) moved = 1'b1;
      end
      checks++;
      if (moved) begin
         errors++;
         $display("FAIL bounce_toggle: got state change during toggling expected none");
      end
      enter_btn = 1'b1;
      n = 0;
      while (n < 30 && state_led !== 2'b01) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 7) begin
         errors++;
         $display("FAIL bounce_latency: got %0d cycles expected 7", n);
      end
      repeat (10) tick();
      checks++;
      if (state_led !== 2'b01) begin
         errors++;
         $display("FAIL bounce_single: got state=%b expected 01", state_led);
      end
      enter_btn = 1'b0;
      repeat (10) tick();
      $display("test_bounce latency=%0d state=%b", n, state_led);
   endtask

   task automatic test_clear_enter;
      bit   ok;
      exp_t e;
      sw = 5'd7;
      press(1'b1, 1'b1);
      checks++;
      if (state_led !== 2'b00 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_enter_state: got state=%b valid=%b expected 00 0", state_led, result_valid);
      end
      checks++;
      if (dut.r_a !== 5'd0 || dut.r_b !== 5'd0) begin
         errors++;
         $display("FAIL clear_enter_regs: got A=%b B=%b expected 00000 00000", dut.r_a, dut.r_b);
      end
      do_calc(2, 3, 2'b00);
      wait_state(2'b11, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || sum !== e.sum) begin
         errors++;
         $display("FAIL clear_calc: got sum=%b state=%b expected %b 11", sum, state_led, e.sum);
      end
      sw = 5'b11011;
      press(1'b0, 1'b1);
      checks++;
      if (state_led !== 2'b00 || result_valid !== 1'b0 || range_err !== 1'b0 || sum !== 6'b111011) begin
         errors++;
         $display("FAIL clear_sh: got state=%b valid=%b rerr=%b sum=%b expected 00 0 0 111011",
                  state_led, result_valid, range_err, sum);
      end
      $display("test_clear_enter done state=%b", state_led);
   endtask

   task automatic test_back_to_back;
      bit   ok;
      exp_t e;
      do_calc(3, 4, 2'b00);
      wait_state(2'b11, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || sum !== e.sum || sum !== 6'd7) begin
         errors++;
         $display("FAIL chain_first: got sum=%b expected %b", sum, e.sum);
      end
      sw = 5'd9;
      press(1'b1, 1'b0);
      checks++;
      if (state_led !== 2'b01 || dut.r_a !== 5'd9 || result_valid !== 1'b0 || range_err !== 1'b0) begin
         errors++;
         $display("FAIL chain_entry: got state=%b A=%0d valid=%b rerr=%b expected 01 9 0 0",
                  state_led, dut.r_a, result_valid, range_err);
      end
      checks++;
      if (sum !== 6'd9) begin
         errors++;
         $display("FAIL chain_preview9: got %b expected 001001", sum);
      end
      sw = 5'b11110;
      tick();
      checks++;
      if (sum !== 6'b111110) begin
         errors++;
         $display("FAIL chain_preview_neg: got %b expected 111110", sum);
      end
      sw = 5'd5;
      op = 2'b00;
      press(1'b1, 1'b0);
      sb.push_back(model(9, 5, 2'b00));
      wait_state(2'b11, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || sum !== e.sum || result_valid !== 1'b1) begin
         errors++;
         $display("FAIL chain_second: got sum=%b valid=%b expected %b 1", sum, result_valid, e.sum);
      end
      $display("test_back_to_back sum=%b", sum);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_range();
      test_reset_mid();
      test_bounce();
      test_clear_enter();
      test_back_to_back();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
